gemm_argmax: RTL
================

# gemm_argmax

Action-selection stage directly downstream of the second GEMM layer in the RL inference path. It consumes the layer's serial stream of K half-precision (fp16) Q-values per frame and emits one action index per frame: the position of the largest value, plus that value. Compare order is total and deterministic, and NaN handling is explicit. Malformed (short) frames are detected and discarded rather than producing a bogus action.

## Interface
Parameters:
- `K`, 4, Q-values per frame (≥2); matches the upstream layer's K.
- `WIDTH`, 16, element width; only 16 (IEEE fp16) is legal; elaboration fails otherwise.
- `IDXW`, `$clog2(K)`, action index width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ivalid`  in  1  element strobe; high exactly while upstream `ovalid` is high.
- `in`  in  16  fp16 Q-value, element index = position within the frame.
- `ovalid`  out  1  one-cycle pulse: `action` / `qmax` / `nan_flag` are valid.
- `action`  out  IDXW  index of the maximum element.
- `qmax`  out  16  maximum element, with −0 returned as 0x0000.
- `nan_flag`  out  1  at least one NaN was present in the frame.
- `err`  out  1  one-cycle pulse: short frame discarded.

## Operation
- Element counter `cnt` (0..K-1) advances on each `ivalid` cycle. The element with `cnt==K-1` closes the frame and `cnt` returns to 0.
- Ordering key per element (the combinational `fp16_key`):
  - NaN (exp=0x1F, mant≠0) → key 0x0000, i.e. below everything; also sets the frame's NaN bit.
  - −0 (0x8000) → canonicalised to 0x0000 before keying.
  - sign=1 → key = ~x.
  - sign=0 → key = x ^ 0x8000.
  - Unsigned key compare gives IEEE numeric order; ±Inf are ordinary values.
- Element 0 loads the best registers unconditionally. A later element replaces the best only if its key is strictly greater, so ties keep the lowest index.
- If all elements are NaN: `action`=0, `qmax`=the first NaN's bits, `nan_flag`=1.
- Frame close: register the result; `ovalid`=1 for exactly one cycle; `action`/`qmax`/`nan_flag` hold until the next `ovalid`.
- Short frame: `ivalid` falls while `cnt`≠0. Then `err` pulses the following cycle, the partial frame is discarded, `cnt`=0, and there is no `ovalid`. Result outputs are unchanged.
- Back-to-back frames (last element of frame n immediately followed by element 0 of frame n+1) are fully supported with no bubble.
- States: IDLE (`cnt`==0, no frame open) and ACC (frame open). Transitions:
  - IDLE→ACC on `ivalid`.
  - ACC→IDLE on the last element, or on `ivalid`=0 (error).
  - For K=1 frames ACC is skipped; not legal per `K`≥2 anyway.

## Timing
- Latency: `ovalid` is asserted the cycle after the last element is sampled (1 cycle).
- `err` is asserted the cycle after the first `ivalid`=0 cycle inside an open frame.
- Throughput: one element per cycle, no backpressure; the block is always ready.
- Reset values (rst=0 at a clock edge):
  - `ovalid`=0, `err`=0, `action`=0, `qmax`=0x0000, `nan_flag`=0, `cnt`=0, state IDLE.
- Reset mid-frame aborts silently: no `err`, no `ovalid`. The first `ivalid` after reset release is element 0.
- `ovalid` and `err` are never high in the same cycle.

## Structure
- Package `gemm_pkg`:
  - `FP16_NAN_EXP` = 5'h1F, `FP16_NEG_ZERO` = 16'h8000, `FP16_POS_ZERO` = 16'h0000.
  - `fp16_t` typedef (16-bit).
  - The `IDXW` derivation function.
- Sub-module `fp16_key`: combinational, fp16 in → 16-bit ordering key + `is_nan`. It is reused later by any max-pool/ReLU stage.
- Top: counter/FSM, best-key/best-value/best-index registers, NaN accumulator, output registers.

## Test plan
- Frame {0x3266, 0x34CD, 0xBD00, 0x3786} (0.2, 0.3, −1.25, 0.47) → one cycle after the 4th element: `ovalid`=1, `action`=3, `qmax`=0x3786, `nan_flag`=0.
- Ties and all-negative, sent as back-to-back frames:
  - {0x3C00, 0x4000, 0x4000, 0x0000} → `action`=1, `qmax`=0x4000.
  - Then {0xBC00, 0xC000, 0xB800, 0xC400} → `action`=2, `qmax`=0xB800.
  - Two `ovalid` pulses exactly 4 cycles apart.
- Signed zero: {0x8000, 0xBC00, 0x0000, 0xC000} → `action`=0, `qmax`=0x0000.
- NaN handling:
  - {0x7E00, 0x3C00, 0xFC00, 0x7C00} → `action`=3 (+Inf), `qmax`=0x7C00, `nan_flag`=1.
  - All {0x7E00} → `action`=0, `nan_flag`=1.
- Short frame and recovery:
  - `ivalid` high for 2 elements, then low → `err` pulse next cycle, no `ovalid`, outputs keep the previous frame.
  - A following full frame is processed correctly.
- Reset during 3rd element of a frame → all outputs 0, no `err`/`ovalid`. A fresh frame after release gives the correct result.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared fp16 constants and types for the GEMM output stages.
package gemm_pkg;

    localparam logic [4:0]  FP16_NAN_EXP  = 5'h1F;
    localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam int          FP16_WIDTH    = 16;

    typedef logic [15:0] fp16_t;

    // Frame tracking: IDLE means no element of a frame has been seen yet.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } argmax_state_t;

    // Width of an index that can address k elements (never narrower than 1 bit).
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/fp16_key.sv
// Maps an fp16 value to an unsigned ordering key whose integer order matches
// IEEE numeric order. NaN maps to the lowest key so it never wins a max.
module fp16_key
    import gemm_pkg::*;
(
    input  fp16_t       x,
    output logic [15:0] key,
    output logic        is_nan,
    output fp16_t       canon
);

    // Canonicalise -0, detect NaN and build the sign-magnitude-to-offset key.
    always_comb begin
        canon  = (x == FP16_NEG_ZERO) ? FP16_POS_ZERO : x;
        is_nan = (x[14:10] == FP16_NAN_EXP) && (x[9:0] != 10'd0);
        key    = 16'h0000;
        if (!is_nan) begin
            if (canon[15]) begin
                key = ~canon;
            end else begin
                key = canon ^ 16'h8000;
            end
        end
    end

endmodule

// File: rtl/gemm_argmax.sv
// Streaming argmax over K fp16 Q-values per frame. Emits the index and value
// of the largest element one cycle after the frame's last element, with NaN
// reporting, lowest-index tie breaking and short-frame discard.
module gemm_argmax
    import gemm_pkg::*;
#(
    parameter  int K     = 4,
    parameter  int WIDTH = 16,
    localparam int IDXW  = idx_width(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid,
    input  logic [WIDTH-1:0] in,
    output logic             ovalid,
    output logic [IDXW-1:0]  action,
    output logic [WIDTH-1:0] qmax,
    output logic             nan_flag,
    output logic             err
);

    // Only IEEE half precision is supported; any other width or a
    // degenerate frame size is rejected at elaboration.
    if (WIDTH != FP16_WIDTH) begin : g_bad_width
        $error("gemm_argmax: WIDTH must be 16 (fp16)");
    end
    if (K < 2) begin : g_bad_k
        $error("gemm_argmax: K must be at least 2");
    end

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

    argmax_state_t   state_reg, state_next;
    logic [IDXW-1:0] cnt_reg, cnt_next;

    logic [15:0]     best_key_reg, best_key_next;
    fp16_t           best_val_reg, best_val_next;
    logic [IDXW-1:0] best_idx_reg, best_idx_next;
    logic            nan_acc_reg, nan_acc_next;

    logic            ovalid_reg, ovalid_next;
    logic            err_reg, err_next;
    logic [IDXW-1:0] action_reg, action_next;
    fp16_t           qmax_reg, qmax_next;
    logic            nan_flag_reg, nan_flag_next;

    logic [15:0]     elem_key;
    logic            elem_nan;
    fp16_t           elem_canon;
    logic            is_last;

    fp16_key u_key (
        .x      (fp16_t'(in)),
        .key    (elem_key),
        .is_nan (elem_nan),
        .canon  (elem_canon)
    );

    assign is_last = (cnt_reg == LAST_IDX);

    // Next-state, running-best update and output-register decisions.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        best_key_next = best_key_reg;
        best_val_next = best_val_reg;
        best_idx_next = best_idx_reg;
        nan_acc_next  = nan_acc_reg;
        ovalid_next   = 1'b0;
        err_next      = 1'b0;
        action_next   = action_reg;
        qmax_next     = qmax_reg;
        nan_flag_next = nan_flag_reg;

        case (state_reg)
            ST_IDLE: begin
                if (ivalid) begin
                    // Element 0 seeds the running best unconditionally, so an
                    // all-NaN frame reports index 0 with the first NaN's bits.
                    best_key_next = elem_key;
                    best_val_next = elem_canon;
                    best_idx_next = '0;
                    nan_acc_next  = elem_nan;
                    cnt_next      = IDXW'(1);
                    state_next    = ST_ACC;
                end
            end
            ST_ACC: begin
                if (ivalid) begin
                    // Strictly greater only: ties keep the earlier index.
                    if (elem_key > best_key_reg) begin
                        best_key_next = elem_key;
                        best_val_next = elem_canon;
                        best_idx_next = cnt_reg;
                    end
                    nan_acc_next = nan_acc_reg | elem_nan;
                    if (is_last) begin
                        cnt_next      = '0;
                        state_next    = ST_IDLE;
                        ovalid_next   = 1'b1;
                        action_next   = best_idx_next;
                        qmax_next     = best_val_next;
                        nan_flag_next = nan_acc_next;
                    end else begin
                        cnt_next = cnt_reg + IDXW'(1);
                    end
                end else begin
                    // Upstream dropped the strobe mid-frame: discard it.
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame-tracking state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Running-best datapath and registered results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            best_key_reg <= 16'h0000;
            best_val_reg <= FP16_POS_ZERO;
            best_idx_reg <= '0;
            nan_acc_reg  <= 1'b0;
            ovalid_reg   <= 1'b0;
            err_reg      <= 1'b0;
            action_reg   <= '0;
            qmax_reg     <= FP16_POS_ZERO;
            nan_flag_reg <= 1'b0;
        end else begin
            best_key_reg <= best_key_next;
            best_val_reg <= best_val_next;
            best_idx_reg <= best_idx_next;
            nan_acc_reg  <= nan_acc_next;
            ovalid_reg   <= ovalid_next;
            err_reg      <= err_next;
            action_reg   <= action_next;
            qmax_reg     <= qmax_next;
            nan_flag_reg <= nan_flag_next;
        end
    end

    assign ovalid   = ovalid_reg;
    assign err      = err_reg;
    assign action   = action_reg;
    assign qmax     = WIDTH'(qmax_reg);
    assign nan_flag = nan_flag_reg;

endmodule
